dcache_miss_sequencer: RTL and testbench
========================================

// Module: dcache_miss_sequencer
// PURPOSE
//  Control FSM for the 2-way, 16-set data-cache SRAM. Sits between the MEM stage and the data memory.
//  Services CPU load/store lookups, stalls the pipeline on a miss, writes back a dirty victim,
//  refills the line from memory and installs it. Word extract/merge is done here; the SRAM only stores lines.
// PARAMETERS
//  ADDR_W  32   CPU/memory byte-address width
//  IDX_W   4    set-index width (16 sets)
//  TAG_W   23   address tag width = ADDR_W-IDX_W-5
//  LINE_W  256  line width (8 words)
//  WORD_W  32   CPU data width
// PORTS
//  clk_i          in   1       clock
//  rst_i          in   1       reset, asynchronous, active-high
//  cpu_req_i      in   1       MEM-stage load/store valid
//  cpu_we_i       in   1       1=store, 0=load
//  cpu_addr_i     in   32      byte address: [31:9] tag, [8:5] index, [4:2] word, [1:0] ignored
//  cpu_data_i     in   32      store data
//  cpu_data_o     out  32      load data, valid when cpu_req_i & ~cpu_stall_o
//  cpu_stall_o    out  1       freeze pipeline
//  sram_enable_o  out  1       SRAM access strobe
//  sram_write_o   out  1       SRAM write (into hit way, else LRU way)
//  sram_addr_o    out  4       set index
//  sram_tag_o     out  25      {valid,dirty,tag[22:0]}
//  sram_data_o    out  256     line to write
//  sram_hit_i     in   1       lookup hit
//  sram_tag_i     in   25      hit tag, or LRU-victim tag on miss
//  sram_data_i    in   256     hit line, or LRU-victim line on miss
//  mem_enable_o   out  1       memory request, one-cycle pulse
//  mem_write_o    out  1       1=write-back, 0=refill read; valid with mem_enable_o
//  mem_addr_o     out  32      line-aligned address ([4:0]=0)
//  mem_data_o     out  256     write-back line
//  mem_ack_i      in   1       one-cycle pulse: write done / read data valid on mem_data_i
//  mem_data_i     in   256     refill line
// BEHAVIOUR
//  Reset: state=IDLE; every output 0; latched address/victim/refill registers 0.
//  States:
//   IDLE: sram_enable_o=cpu_req_i, combinational lookup on cpu_addr_i.
//   - hit & load: cpu_stall_o=0; cpu_data_o = sram_data_i word [4:2]; 0-cycle latency.
//   - hit & store: sram_write_o=1; line with word merged; tag {1,1,tag}; no stall.
//   - miss: cpu_stall_o=1; latch addr, victim tag/data.
//     Go to WB_REQ if victim valid&dirty, else RF_REQ.
//   WB_REQ: mem_enable_o=1, mem_write_o=1.
//     mem_addr_o={victim_tag,index,5'b0}, mem_data_o=victim line -> WB_WAIT.
//   WB_WAIT: hold; on mem_ack_i -> RF_REQ.
//   RF_REQ: mem_enable_o=1, mem_write_o=0, mem_addr_o={req_tag,index,5'b0} -> RF_WAIT.
//   RF_WAIT: hold; on mem_ack_i latch mem_data_i -> INSTALL.
//   INSTALL: sram_enable_o=sram_write_o=1, tag {1,0,req_tag}, data=refill line -> IDLE.
//     IDLE then replays as a hit; a store sets dirty there.
//  cpu_stall_o=1 in every non-IDLE state, and in IDLE on cpu_req_i & ~sram_hit_i.
//  mem_ack_i outside WB_WAIT/RF_WAIT is ignored. mem_enable_o is never asserted twice per transaction.
//  cpu_req_i/cpu_addr_i changing while stalled: ignored (latched copy used until IDLE).
//  Reset mid-operation: async return to IDLE; in-flight memory transaction abandoned; no SRAM write.
//  Miss penalty, clean victim = 2 + memory latency; dirty victim adds 1 + write latency.
// STRUCTURE
//  Shared package dcache_pkg: state enum, address field widths/offsets, tag-word bit positions
//  (VALID=24, DIRTY=23).
//  One sub-module: dcache_word_merge (word select for loads, word insert for stores), combinational.
//  FSM, latches and memory-request logic stay in this module.
// TESTING
//  1 cold load 0x0000_0040: RF_REQ mem_addr 0x40; ack with line word2=0xA5A5_0001.
//    INSTALL tag {1,0,0}; then cpu_data_o=0xA5A5_0001 unstalled.
//  2 store 0xDEAD_BEEF to 0x44 after 1: no stall; sram_write_o=1; tag dirty=1; word1 merged only.
//  3 fill set 2 with two dirty lines, load 0x0000_2040: WB_REQ to victim address, mem_write_o=1.
//    After ack, RF_REQ to 0x2040.
//  4 mem_ack_i pulsed in IDLE and RF_REQ: no state change; mem_enable_o exactly one pulse per request.
//  5 rst_i during RF_WAIT: all outputs 0 immediately; later ack ignored; next load re-misses cleanly.
//  6 back-to-back hit load/store/load to same line: zero stall cycles; final load returns stored data.

Source files
------------

// File: rtl/dcache_pkg.sv
// dcache_pkg: widths, address-field offsets, tag-word bit positions and FSM encodings
// shared by the data-cache miss sequencer and its word-merge helper.
package dcache_pkg;
  localparam int ADDR_W    = 32;
  localparam int IDX_W     = 4;
  localparam int OFF_W     = 5;
  localparam int TAG_W     = ADDR_W - IDX_W - OFF_W;
  localparam int LINE_W    = 256;
  localparam int WORD_W    = 32;
  localparam int WSEL_W    = 3;
  localparam int WSEL_LSB  = 2;
  localparam int TAGW_W    = TAG_W + 2;
  localparam int VALID_BIT = 24;
  localparam int DIRTY_BIT = 23;
  typedef logic [2:0] state_t;
  localparam state_t IDLE    = 3'd0;
  localparam state_t WB_REQ  = 3'd1;
  localparam state_t WB_WAIT = 3'd2;
  localparam state_t RF_REQ  = 3'd3;
  localparam state_t RF_WAIT = 3'd4;
  localparam state_t INSTALL = 3'd5;
  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic [IDX_W-1:0] idx;
  } line_addr_t;
  function automatic logic [ADDR_W-1:0] line_base(input logic [TAG_W-1:0] tag,
                                                 input logic [IDX_W-1:0] idx);
    return {tag, idx, {OFF_W{1'b0}}};
  endfunction
endpackage

// File: rtl/dcache_word_merge.sv
// dcache_word_merge: selects one word of a cache line for loads and
// inserts a store word into a copy of the line.
module dcache_word_merge
  import dcache_pkg::*;
(
  input  logic [LINE_W-1:0] line_i,
  input  logic [WSEL_W-1:0] sel_i,
  input  logic [WORD_W-1:0] word_i,
  output logic [WORD_W-1:0] word_o,
  output logic [LINE_W-1:0] line_o
);
  assign word_o = line_i[sel_i*WORD_W +: WORD_W];
  always_comb begin
    line_o = line_i;
    line_o[sel_i*WORD_W +: WORD_W] = word_i;
  end
endmodule

// File: rtl/dcache_miss_sequencer.sv
// dcache_miss_sequencer: lookup/write-back/refill/install controller for the
// 2-way, 16-set data cache; stalls the MEM stage while a miss is serviced.
module dcache_miss_sequencer
  import dcache_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              cpu_req_i,
  input  logic              cpu_we_i,
  input  logic [ADDR_W-1:0] cpu_addr_i,
  input  logic [WORD_W-1:0] cpu_data_i,
  output logic [WORD_W-1:0] cpu_data_o,
  output logic              cpu_stall_o,
  output logic              sram_enable_o,
  output logic              sram_write_o,
  output logic [IDX_W-1:0]  sram_addr_o,
  output logic [TAGW_W-1:0] sram_tag_o,
  output logic [LINE_W-1:0] sram_data_o,
  input  logic              sram_hit_i,
  input  logic [TAGW_W-1:0] sram_tag_i,
  input  logic [LINE_W-1:0] sram_data_i,
  output logic              mem_enable_o,
  output logic              mem_write_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [LINE_W-1:0] mem_data_o,
  input  logic              mem_ack_i,
  input  logic [LINE_W-1:0] mem_data_i
);
  state_t            state_q, state_d;
  line_addr_t        req_q, req_d;
  logic [TAG_W-1:0]  vtag_q, vtag_d;
  logic [LINE_W-1:0] vline_q, vline_d, rline_q, rline_d;
  line_addr_t        cpu_la;
  logic              lookup, hit, miss, inst, wb_req, rf_req, unused;
  logic [WORD_W-1:0] rd_word;
  logic [LINE_W-1:0] st_line;

  assign unused = ^cpu_addr_i[WSEL_LSB-1:0];
  assign cpu_la = cpu_addr_i[ADDR_W-1:OFF_W];

  dcache_word_merge u_merge (
    .line_i (sram_data_i),
    .sel_i  (cpu_addr_i[WSEL_LSB +: WSEL_W]),
    .word_i (cpu_data_i),
    .word_o (rd_word),
    .line_o (st_line)
  );

  assign lookup = state_q == IDLE && cpu_req_i;
  assign hit    = lookup && sram_hit_i;
  assign miss   = lookup && !sram_hit_i;
  assign inst   = state_q == INSTALL;
  assign wb_req = state_q == WB_REQ;
  assign rf_req = state_q == RF_REQ;

  // Miss capture uses the live lookup; every later state works off the latched copies.
  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    vtag_d  = vtag_q;
    vline_d = vline_q;
    rline_d = rline_q;
    case (state_q)
      IDLE: if (miss) begin
        req_d   = cpu_la;
        vtag_d  = sram_tag_i[TAG_W-1:0];
        vline_d = sram_data_i;
        state_d = sram_tag_i[VALID_BIT] && sram_tag_i[DIRTY_BIT] ? WB_REQ : RF_REQ;
      end
      WB_REQ:  state_d = WB_WAIT;
      WB_WAIT: state_d = mem_ack_i ? RF_REQ : WB_WAIT;
      RF_REQ:  state_d = RF_WAIT;
      RF_WAIT: if (mem_ack_i) begin
        rline_d = mem_data_i;
        state_d = INSTALL;
      end
      INSTALL: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      req_q   <= '0;
      vtag_q  <= '0;
      vline_q <= '0;
      rline_q <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      vtag_q  <= vtag_d;
      vline_q <= vline_d;
      rline_q <= rline_d;
    end
  end

  assign cpu_stall_o   = state_q != IDLE || miss;
  assign cpu_data_o    = hit && !cpu_we_i ? rd_word : '0;
  assign sram_enable_o = lookup || inst;
  assign sram_write_o  = (hit && cpu_we_i) || inst;
  assign sram_addr_o   = inst ? req_q.idx : lookup ? cpu_la.idx : '0;
  // A store hit marks the line dirty; a fresh install is always clean.
  assign sram_tag_o    = inst ? {1'b1, 1'b0, req_q.tag} : lookup ? {1'b1, cpu_we_i, cpu_la.tag} : '0;
  assign sram_data_o   = inst ? rline_q : hit && cpu_we_i ? st_line : '0;
  assign mem_enable_o  = wb_req || rf_req;
  assign mem_write_o   = wb_req;
  assign mem_addr_o    = wb_req ? line_base(vtag_q, req_q.idx) : rf_req ? line_base(req_q.tag, req_q.idx) : '0;
  assign mem_data_o    = wb_req ? vline_q : '0;
endmodule

// File: tb/tb_dcache_miss_sequencer.sv
// tb_dcache_miss_sequencer: directed bench with a behavioural 2-way SRAM and a hand-driven memory.
module tb_dcache_miss_sequencer;
  logic         clk_i = 1'b0;
  logic         rst_i;
  logic         cpu_req_i, cpu_we_i;
  logic [31:0]  cpu_addr_i, cpu_data_i, cpu_data_o;
  logic         cpu_stall_o, sram_enable_o, sram_write_o;
  logic [3:0]   sram_addr_o;
  logic [24:0]  sram_tag_o, sram_tag_i;
  logic [255:0] sram_data_o, sram_data_i;
  logic         sram_hit_i;
  logic         mem_enable_o, mem_write_o, mem_ack_i;
  logic [31:0]  mem_addr_o;
  logic [255:0] mem_data_o, mem_data_i;
  int total = 0;
  int bad = 0;

  always #5 clk_i = ~clk_i;

  dcache_miss_sequencer dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .cpu_req_i(cpu_req_i), .cpu_we_i(cpu_we_i), .cpu_addr_i(cpu_addr_i),
    .cpu_data_i(cpu_data_i), .cpu_data_o(cpu_data_o), .cpu_stall_o(cpu_stall_o),
    .sram_enable_o(sram_enable_o), .sram_write_o(sram_write_o), .sram_addr_o(sram_addr_o),
    .sram_tag_o(sram_tag_o), .sram_data_o(sram_data_o), .sram_hit_i(sram_hit_i),
    .sram_tag_i(sram_tag_i), .sram_data_i(sram_data_i),
    .mem_enable_o(mem_enable_o), .mem_write_o(mem_write_o), .mem_addr_o(mem_addr_o),
    .mem_data_o(mem_data_o), .mem_ack_i(mem_ack_i), .mem_data_i(mem_data_i)
  );

  // Behavioural 2-way SRAM: LRU moves only on a hit or a write.
  logic [24:0]  m_tag [16][2];
  logic [255:0] m_dat [16][2];
  logic [15:0]  m_lru;
  logic         w0, w1, way;
  always_comb begin
    w0 = m_tag[sram_addr_o][0][24] && m_tag[sram_addr_o][0][22:0] == sram_tag_o[22:0];
    w1 = m_tag[sram_addr_o][1][24] && m_tag[sram_addr_o][1][22:0] == sram_tag_o[22:0];
    way = w1 ? 1'b1 : w0 ? 1'b0 : m_lru[sram_addr_o];
    sram_hit_i = w0 || w1;
    sram_tag_i = m_tag[sram_addr_o][way];
    sram_data_i = m_dat[sram_addr_o][way];
  end
  always @(posedge clk_i) begin
    if (sram_enable_o && sram_write_o) begin
      m_tag[sram_addr_o][way] <= sram_tag_o;
      m_dat[sram_addr_o][way] <= sram_data_o;
    end
    if (sram_enable_o && (sram_write_o || sram_hit_i)) m_lru[sram_addr_o] <= ~way;
  end

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic clk1;
    @(posedge clk_i);
    #1;
  endtask

  function automatic logic [255:0] mk(input logic [31:0] b);
    logic [255:0] l;
    for (int i = 0; i < 8; i++) l[i*32 +: 32] = b + 32'(i);
    return l;
  endfunction

  logic [255:0] l1, l1_st, l2, l3, l4;

  initial begin
    for (int s = 0; s < 16; s++)
      for (int w = 0; w < 2; w++) begin
        m_tag[s][w] = '0;
        m_dat[s][w] = '0;
      end
    m_lru = '0;
    l1 = mk(32'h1000_0000);
    l1[31:0] = 32'hA5A5_0001;
    l1[95:64] = 32'hA5A5_0001;
    l1_st = l1;
    l1_st[63:32] = 32'hDEAD_BEEF;
    l2 = mk(32'h2000_0000);
    l3 = mk(32'h3000_0000);
    l4 = mk(32'h4000_0000);
    rst_i = 1'b1; cpu_req_i = 0; cpu_we_i = 0; cpu_addr_i = 0; cpu_data_i = 0;
    mem_ack_i = 0; mem_data_i = '0;
    #1;
    chk("rst_stall", 256'(cpu_stall_o), 0);
    chk("rst_mem_en", 256'(mem_enable_o), 0);
    chk("rst_sram_en", 256'(sram_enable_o), 0);
    chk("rst_mem_addr", 256'(mem_addr_o), 0);
    clk1; clk1;
    rst_i = 1'b0;
    // 1: cold load 0x40
    cpu_req_i = 1; cpu_addr_i = 32'h40; #1;
    chk("t1_miss_stall", 256'(cpu_stall_o), 1);
    chk("t1_idle_no_mem", 256'(mem_enable_o), 0);
    clk1;
    chk("t1_rf_en", 256'(mem_enable_o), 1);
    chk("t1_rf_wr", 256'(mem_write_o), 0);
    chk("t1_rf_addr", 256'(mem_addr_o), 32'h40);
    clk1;
    chk("t1_wait_en", 256'(mem_enable_o), 0);
    mem_ack_i = 1; mem_data_i = l1;
    clk1;
    mem_ack_i = 0; #1;
    chk("t1_inst_wr", 256'({sram_enable_o, sram_write_o}), 2'b11);
    chk("t1_inst_tag", 256'(sram_tag_o), 25'h100_0000);
    chk("t1_inst_data", sram_data_o, l1);
    chk("t1_inst_idx", 256'(sram_addr_o), 2);
    clk1;
    chk("t1_hit_stall", 256'(cpu_stall_o), 0);
    chk("t1_hit_data", 256'(cpu_data_o), 32'hA5A5_0001);
    cpu_addr_i = 32'h48; #1;
    chk("t1_w2_data", 256'(cpu_data_o), 32'hA5A5_0001);
    clk1;
    // 2: store hit to 0x44
    cpu_we_i = 1; cpu_addr_i = 32'h44; cpu_data_i = 32'hDEAD_BEEF; #1;
    chk("t2_stall", 256'(cpu_stall_o), 0);
    chk("t2_wr", 256'(sram_write_o), 1);
    chk("t2_tag", 256'(sram_tag_o), 25'h180_0000);
    chk("t2_line", sram_data_o, l1_st);
    clk1;
    // 3: second line in set 2, made dirty, then a third tag evicts 0x40
    cpu_we_i = 0; cpu_addr_i = 32'h240; #1;
    chk("t3_miss1", 256'(cpu_stall_o), 1);
    clk1;
    chk("t3_rf1_addr", 256'(mem_addr_o), 32'h240);
    clk1;
    mem_ack_i = 1; mem_data_i = l2;
    clk1;
    mem_ack_i = 0;
    clk1;
    cpu_we_i = 1; cpu_data_i = 32'h0000_1234; #1;
    chk("t3_store_hit", 256'({cpu_stall_o, sram_write_o}), 2'b01);
    clk1;
    cpu_we_i = 0; cpu_addr_i = 32'h2040; #1;
    chk("t3_miss2", 256'(cpu_stall_o), 1);
    clk1;
    cpu_addr_i = 32'hFFFF_FFE0;
    #1;
    chk("t3_wb_en", 256'({mem_enable_o, mem_write_o}), 2'b11);
    chk("t3_wb_addr", 256'(mem_addr_o), 32'h40);
    chk("t3_wb_data", mem_data_o, l1_st);
    clk1;
    chk("t3_wbw_en", 256'(mem_enable_o), 0);
    clk1;
    chk("t3_wbw_hold", 256'({cpu_stall_o, mem_enable_o}), 2'b10);
    mem_ack_i = 1;
    clk1;
    // 4: ack during RF_REQ is ignored
    chk("t4_rf_en", 256'({mem_enable_o, mem_write_o}), 2'b10);
    chk("t3_rf2_addr", 256'(mem_addr_o), 32'h2040);
    clk1;
    mem_ack_i = 0; cpu_addr_i = 32'h2040; #1;
    chk("t4_rfw_en", 256'(mem_enable_o), 0);
    chk("t4_rfw_stall", 256'(cpu_stall_o), 1);
    clk1;
    chk("t4_rfw_hold", 256'({sram_enable_o, mem_enable_o}), 0);
    mem_ack_i = 1; mem_data_i = l3;
    clk1;
    mem_ack_i = 0; #1;
    chk("t3_inst_tag", 256'(sram_tag_o), 25'h100_0010);
    chk("t3_inst_data", sram_data_o, l3);
    clk1;
    chk("t3_replay", 256'({cpu_stall_o, cpu_data_o}), {1'b0, 32'h3000_0000});
    clk1;
    cpu_req_i = 0; mem_ack_i = 1;
    clk1;
    mem_ack_i = 0; #1;
    chk("t4_idle_ack", 256'({cpu_stall_o, mem_enable_o}), 0);
    cpu_req_i = 1; cpu_addr_i = 32'h2044; #1;
    chk("t4_still_idle", 256'({cpu_stall_o, cpu_data_o}), {1'b0, 32'h3000_0001});
    clk1;
    // 5: reset during RF_WAIT
    cpu_addr_i = 32'h60; #1;
    chk("t5_miss", 256'(cpu_stall_o), 1);
    clk1; clk1;
    rst_i = 1; cpu_req_i = 0; #1;
    chk("t5_rst_outs", 256'({cpu_stall_o, mem_enable_o, sram_enable_o, sram_write_o}), 0);
    clk1;
    rst_i = 0; mem_ack_i = 1; mem_data_i = l4;
    clk1;
    mem_ack_i = 0; #1;
    chk("t5_late_ack", 256'({cpu_stall_o, sram_enable_o, mem_enable_o}), 0);
    cpu_req_i = 1; #1;
    chk("t5_remiss", 256'(cpu_stall_o), 1);
    clk1;
    chk("t5_rf_addr", 256'({mem_enable_o, mem_addr_o}), {1'b1, 32'h60});
    clk1;
    mem_ack_i = 1;
    clk1;
    mem_ack_i = 0; #1;
    chk("t5_inst_idx", 256'(sram_addr_o), 3);
    clk1;
    chk("t5_hit", 256'({cpu_stall_o, cpu_data_o}), {1'b0, 32'h4000_0000});
    // 6: back-to-back hits on one line
    cpu_addr_i = 32'h64; #1;
    chk("t6_ld1", 256'({cpu_stall_o, cpu_data_o}), {1'b0, 32'h4000_0001});
    clk1;
    cpu_we_i = 1; cpu_data_i = 32'hCAFE_F00D; #1;
    chk("t6_st", 256'({cpu_stall_o, sram_write_o}), 2'b01);
    clk1;
    cpu_we_i = 0; #1;
    chk("t6_ld2", 256'({cpu_stall_o, cpu_data_o}), {1'b0, 32'hCAFE_F00D});
    clk1;
    cpu_req_i = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
